// File: rtl/reindeer_wb_arbiter_if.sv
// Wishbone classic link between one host and one peripheral.
// The host drives the master modport. The peripheral drives the slave modport.
interface reindeer_wb_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [DATA_BITS/8-1:0] sel;
    logic [ADDR_BITS-1:0]   adr;
    logic [DATA_BITS-1:0]   dat_w;
    logic [DATA_BITS-1:0]   dat_r;
    logic                   ack;
    logic                   err;

    // The peripheral side of the arbiter has no error input, so err is host-facing only.
    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/reindeer_wb_arbiter.sv
// Round-robin arbiter for two Wishbone hosts sharing one peripheral, with a bus watchdog.
// Grant is given 1 cycle after request. The losing host is stalled with no ack until it wins.
module reindeer_wb_arbiter #(
    parameter int                   ADDR_BITS = 16,
    parameter int                   DATA_BITS = 32,
    parameter int                   TIMEOUT   = 255,
    parameter logic [DATA_BITS-1:0] ERR_DATA  = DATA_BITS'(32'hDEADBEEF)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    reindeer_wb_arbiter_if.slave  m0,
    reindeer_wb_arbiter_if.slave  m1,
    reindeer_wb_arbiter_if.master s,
    output logic [1:0]            grant,
    output logic                  bus_error,
    output logic [7:0]            err_count
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t         state;
    logic           last;
    logic [15:0]    timer;

    logic           req0;
    logic           req1;
    logic           busy;
    logic           own1;
    logic           own_cyc;
    logic           own_stb;
    logic           expired;
    logic           timeout;
    logic           done;
    logic [DATA_BITS-1:0] rdat;

    assign req0    = m0.cyc & m0.stb;
    assign req1    = m1.cyc & m1.stb;
    assign busy    = (state == BUSY);
    assign own1    = grant[1];
    assign own_cyc = own1 ? m1.cyc : m0.cyc;
    assign own_stb = own1 ? m1.stb : m0.stb;
    assign expired = (timer == TIMER_LAST);
    // A real ack in the expiry cycle wins over the watchdog.
    assign timeout = busy & own_cyc & ~s.ack & expired;
    assign done    = busy & own_cyc & (s.ack | expired);
    assign rdat    = timeout ? ERR_DATA : s.dat_r;

    always_comb begin
        s.cyc   = busy & own_cyc;
        s.stb   = busy & own_cyc & own_stb;
        s.we    = 1'b0;
        s.sel   = '0;
        s.adr   = '0;
        s.dat_w = '0;
        if (busy) begin
            s.we    = own1 ? m1.we    : m0.we;
            s.sel   = own1 ? m1.sel   : m0.sel;
            s.adr   = own1 ? m1.adr   : m0.adr;
            s.dat_w = own1 ? m1.dat_w : m0.dat_w;
        end
    end

    assign m0.dat_r = (busy & grant[0]) ? rdat : '0;
    assign m0.ack   = grant[0] & done;
    assign m0.err   = grant[0] & timeout;
    assign m1.dat_r = (busy & grant[1]) ? rdat : '0;
    assign m1.ack   = grant[1] & done;
    assign m1.err   = grant[1] & timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last      <= 1'b1;
            timer     <= '0;
            bus_error <= 1'b0;
            err_count <= '0;
        end else if (sync_reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last      <= 1'b1;
            timer     <= '0;
            bus_error <= 1'b0;
            err_count <= '0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (req0 | req1) begin
                        grant <= (req0 & (~req1 | last)) ? 2'b01 : 2'b10;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Abort, ack and watchdog expiry all end the cycle the same way.
                    if (!own_cyc || s.ack || expired) begin
                        state <= RELEASE;
                        grant <= 2'b00;
                        last  <= own1;
                        timer <= '0;
                        if (timeout) begin
                            bus_error <= 1'b1;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: doc/reindeer_wb_arbiter.md
Name: reindeer_wb_arbiter

Overview:
- Two-host arbiter sharing the single Wishbone peripheral bus behind the memory-mapped register block.
- Host 0 is the core's MM-register Wishbone host. Host 1 is the debug/on-chip-debugger host.
- Round-robin grant with a bus watchdog: a silent peripheral cannot hang the core. On timeout the arbiter terminates the cycle with an error acknowledge.

Parameters:
- ADDR_BITS, 16, width of Wishbone address (set to MM_REG_ADDR_BITS at instantiation)
- DATA_BITS, 32, data width (XLEN)
- TIMEOUT, 255, max cycles in BUSY awaiting slave ACK; legal range 2..65535
- ERR_DATA, 32'hDEADBEEF, read data returned to host on timeout

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset, same effect as reset_n
- M0_CYC_I / M0_STB_I / M0_WE_I  in  1 each  host 0 cycle / strobe / write
- M0_SEL_I  in  DATA_BITS/8  host 0 byte lanes
- M0_ADR_I  in  ADDR_BITS  host 0 address
- M0_DAT_I  in  DATA_BITS  host 0 write data
- M0_DAT_O  out  DATA_BITS  host 0 read data
- M0_ACK_O  out  1  host 0 acknowledge
- M0_ERR_O  out  1  host 0 error acknowledge
- M1_*: same set as M0_* for host 1
- S_CYC_O / S_STB_O / S_WE_O  out  1 each  slave-side bus
- S_SEL_O  out  DATA_BITS/8  slave byte lanes
- S_ADR_O  out  ADDR_BITS  slave address
- S_DAT_O  out  DATA_BITS  slave write data
- S_DAT_I  in  DATA_BITS  slave read data
- S_ACK_I  in  1  slave acknowledge
- grant  out  2  one-hot current owner (00 idle)
- bus_error  out  1  one-cycle pulse on timeout
- err_count  out  8  saturating timeout count

Behaviour:
- Reset (async or sync_reset): state IDLE, grant=00, last=1 (host 0 wins first tie), timer=0, all S_* outputs 0, M*_ACK_O/M*_ERR_O 0, M*_DAT_O 0, bus_error 0, err_count 0.
- req_n = Mn_CYC_I & Mn_STB_I.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - Only one request: grant it.
  - Both requesting: grant the host that is not `last`.
  - Registered transition to BUSY. Grant latency is 1 cycle after request.
- BUSY:
  - S_CYC_O=S_STB_O=1.
  - S_WE/SEL/ADR/DAT are combinationally muxed from the granted host.
  - S_DAT_I goes to the granted host's DAT_O; the other host's DAT_O holds 0.
  - S_ACK_I routes combinationally to the granted host's ACK_O only.
  - timer increments each BUSY cycle.
- BUSY exits:
  - S_ACK_I=1: go to RELEASE, last <= owner, timer <= 0.
  - S_ACK_I=0 and timer==TIMEOUT-1:
    - Granted ERR_O=1 and ACK_O=1 for that cycle.
    - Granted DAT_O = ERR_DATA.
    - S_STB_O still 1 this cycle.
    - bus_error pulses next cycle.
    - err_count increments, saturating at 255.
    - Go to RELEASE.
  - S_ACK_I and timeout in the same cycle: treat as a normal ACK, no error.
  - Granted host drops CYC_I before ACK (abort): S_CYC_O/S_STB_O fall the same cycle (combinational gating). Go to RELEASE with no ACK/ERR. last <= owner.
- RELEASE:
  - Exactly one cycle, S_CYC_O=S_STB_O=0, grant=00.
  - Returns to IDLE, giving the slave a guaranteed idle cycle.
  - Back-to-back transfers therefore take 3 cycles minimum each (IDLE, BUSY, RELEASE) with a zero-wait slave.
- Non-granted host sees ACK_O=ERR_O=0 and must hold its request. Requests are never dropped.
- The non-owner's request never affects S_* outputs.

Test Plan:
- Host 0 single write: ADR=0x0010, DAT=0x12345678, SEL=0xF, slave ACK on first BUSY cycle -> S_STB high exactly 1 cycle with matching values, M0_ACK_O 1 cycle, grant 01→00, M1 outputs 0.
- Both hosts request reads in the same cycle after reset:
  - host 0 granted first;
  - host 1 granted in the IDLE after RELEASE;
  - repeat the simultaneous request and host 0 is granted next (alternation);
  - each host receives its own S_DAT_I value (0xAAAA0000 / 0x0000BBBB).
- Slave never ACKs with TIMEOUT=8 -> M1_ERR_O and M1_ACK_O asserted on the 8th BUSY cycle, M1_DAT_O=0xDEADBEEF, bus_error 1-cycle pulse, err_count 0→1.
- Slave ACK lands on exactly the TIMEOUT-th cycle -> normal ACK, no ERR_O, err_count unchanged.
- Host 0 deasserts CYC mid-BUSY -> S_CYC_O low the same cycle, no ACK, RELEASE then pending host 1 granted.
- reset_n asserted during BUSY; separately, sync_reset during BUSY -> all outputs return to reset values immediately (async) / next edge (sync); 300 forced timeouts saturate err_count at 255.
